ps2_key_receiver: RTL and testbench

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_key_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, prefix codes and frame check for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // A frame is good when the stop bit is high and data plus parity hold an odd number of ones.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity, input logic stop);
    return stop & (^{parity, data});
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer, run-length glitch filter and falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // The counter tracks how many consecutive samples disagree with the accepted level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_fall  <= r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame receiver with make/break/extended decoding
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       ps2_ext,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic w_clk_fall;
  logic w_clk_level_unused;
  logic w_data;
  logic w_data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clk   (clock),
    .i_reset (reset),
    .i_line  (ps2_clock_in),
    .o_level (w_clk_level_unused),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .i_clk   (clock),
    .i_reset (reset),
    .i_line  (ps2_data_in),
    .o_level (w_data),
    .o_fall  (w_data_fall_unused)
  );

  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timeout;

  ps2_state_t    w_state_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_parity_nxt;
  logic [TW-1:0] w_timeout_nxt;
  logic          w_byte_done;
  logic          w_frame_err;

  logic [7:0]    r_out;
  logic          r_ext;
  logic          r_key_pressed;
  logic          r_frame_error;
  logic          r_break_pending;
  logic          r_ext_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_timeout <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // A strobe always wins over the timeout, so an arriving bit restarts the idle count.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_timeout_nxt = '0;
    w_byte_done   = 1'b0;
    w_frame_err   = 1'b0;
    if (w_clk_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
          end else begin
            w_frame_err = 1'b1;
          end
        end
        DATA: begin
          w_shift_nxt = {w_data, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          w_parity_nxt = w_data;
          w_state_nxt  = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (frame_ok(r_shift, r_parity, w_data)) begin
            w_byte_done = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_timeout == TO_LAST) begin
        w_state_nxt = IDLE;
        w_frame_err = 1'b1;
      end else begin
        w_timeout_nxt = r_timeout + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out           <= 8'h00;
      r_ext           <= 1'b0;
      r_key_pressed   <= 1'b0;
      r_frame_error   <= 1'b0;
      r_break_pending <= 1'b0;
      r_ext_pending   <= 1'b0;
    end else begin
      r_key_pressed <= 1'b0;
      r_frame_error <= w_frame_err;
      if (w_frame_err) begin
        r_break_pending <= 1'b0;
        r_ext_pending   <= 1'b0;
      end else if (w_byte_done) begin
        if (r_shift == BREAK_CODE) begin
          r_break_pending <= 1'b1;
        end else if (r_shift == EXT_CODE) begin
          r_ext_pending <= 1'b1;
        end else if (r_break_pending) begin
          r_break_pending <= 1'b0;
          r_ext_pending   <= 1'b0;
        end else begin
          r_out         <= r_shift;
          r_ext         <= r_ext_pending;
          r_key_pressed <= 1'b1;
          r_ext_pending <= 1'b0;
        end
      end
    end
  end

  assign ps2_out         = r_out;
  assign ps2_ext         = r_ext;
  assign ps2_key_pressed = r_key_pressed;
  assign frame_error     = r_frame_error;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - directed and randomized checks of ps2_key_receiver against a key-event model
module tb_ps2_key_receiver;

  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       key_pressed;
  logic [7:0] key_out;
  logic       key_ext;
  logic       frame_err;

  ps2_key_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clock           (clk),
    .reset           (rst),
    .ps2_clock_in    (ps2c),
    .ps2_data_in     (ps2d),
    .ps2_key_pressed (key_pressed),
    .ps2_out         (key_out),
    .ps2_ext         (key_ext),
    .frame_error     (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int key_count = 0;
  int err_count = 0;
  int overlap = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_pressed && frame_err) overlap++;
      if ((key_pressed || frame_err) && prev_pulse) overlap++;
      if (key_pressed) key_count++;
      if (frame_err) err_count++;
      prev_pulse = key_pressed || frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Key-event model: what a host would expect from the byte stream alone.
  bit         m_break = 0;
  bit         m_ext_pend = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_ext = 1'b0;
  int         exp_key = 0;
  int         exp_err = 0;

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_break = 1;
    else if (b == 8'hE0) m_ext_pend = 1;
    else if (m_break) begin
      m_break = 0;
      m_ext_pend = 0;
    end else begin
      m_out = b;
      m_ext = m_ext_pend;
      m_ext_pend = 0;
      exp_key++;
    end
  endtask

  task automatic model_error();
    exp_err++;
    m_break = 0;
    m_ext_pend = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_keys"}, key_count, exp_key);
    check({tag, "_errs"}, err_count, exp_err);
    check({tag, "_out"}, {24'd0, key_out}, {24'd0, m_out});
    check({tag, "_ext"}, {31'd0, key_ext}, {31'd0, m_ext});
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2d = bits[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    @(negedge clk) ps2d = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    repeat (30) @(negedge clk);
    if (bad_par || bad_stop) model_error();
    else model_byte(b);
    check_state(tag);
  endtask

  task automatic glitch(input int len);
    @(negedge clk) ps2c = 1'b0;
    repeat (len) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse"}, {31'd0, key_pressed}, 32'd0);
    check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_out"}, {24'd0, key_out}, 32'd0);
    check({tag, "_ext"}, {31'd0, key_ext}, 32'd0);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    bit bp;
    bit bs;

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h23, 0, 0, "make_23");
    send_frame(8'hF0, 0, 0, "break_f0");
    send_frame(8'h23, 0, 0, "break_23");
    send_frame(8'h1C, 1, 0, "badpar_1c");
    send_frame(8'h1C, 0, 0, "good_1c");
    send_frame(8'hE0, 0, 0, "ext_e0");
    send_frame(8'h75, 0, 0, "ext_75");
    send_frame(8'h72, 0, 0, "plain_72");
    send_frame(8'h55, 0, 1, "badstop_55");
    send_frame(8'hF0, 0, 0, "break_before_err");
    send_frame(8'h1C, 1, 0, "err_clears_break");
    send_frame(8'h1C, 0, 0, "after_err_1c");

    send_bits(make_frame(8'h3A, 0, 0), 5);
    repeat (TO - 100) @(negedge clk);
    check("timeout_early", err_count, exp_err);
    repeat (200) @(negedge clk);
    model_error();
    check("timeout_fired", err_count, exp_err);
    check("timeout_nokey", key_count, exp_key);
    send_frame(8'h1C, 0, 0, "post_timeout_1c");

    glitch(FILT - 1);
    check("glitch_short", err_count, exp_err);
    glitch(FILT);
    model_error();
    check("glitch_full", err_count, exp_err);

    send_frame(8'hE0, 0, 0, "pre_reset_e0");
    send_bits(make_frame(8'h4D, 0, 0), 5);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    m_break = 0;
    m_ext_pend = 0;
    m_out = 8'h00;
    m_ext = 1'b0;
    repeat (40) @(negedge clk);
    check("reset_no_err", err_count, exp_err);
    send_frame(8'h2B, 0, 0, "post_reset_2b");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hF0;
      else if (r < 4) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      bp = (r == 9);
      bs = (r == 8) && ($urandom_range(0, 1) == 1);
      send_frame(b, bp, bs, $sformatf("rand%0d", i));
    end

    check("pulse_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
